// File: rtl/register_scoreboard.sv
// Per-register remaining-latency scoreboard that stalls ID until a pending result is forwardable.
// Optional SCOREBOARD_STATS_EN adds a saturating stall_cycles counter output.
module register_scoreboard #(
    parameter int NUM_REGS = 16,
    parameter int LAT_W    = 2,
    localparam int IDX_W   = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_valid,
    input  logic                issue_we,
    input  logic [IDX_W-1:0]    issue_rd,
    input  logic [LAT_W-1:0]    issue_lat,
    input  logic                hold,
    input  logic [IDX_W-1:0]    rs1,
    input  logic [IDX_W-1:0]    rs2,
    input  logic                rs1_used,
    input  logic                rs2_used,
    output logic                stall_ID,
    output logic                busy_rs1,
    output logic                busy_rs2,
`ifdef SCOREBOARD_STATS_EN
    output logic [31:0]         stall_cycles,
`endif
    output logic [NUM_REGS-1:0] pending_mask
);

    logic [LAT_W-1:0] cnt [NUM_REGS];
    logic             accept;

    always_comb begin
        pending_mask = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            pending_mask[r] = (cnt[r] != '0);
        end
    end

    assign busy_rs1 = rs1_used & pending_mask[rs1];
    assign busy_rs2 = rs2_used & pending_mask[rs2];
    assign stall_ID = busy_rs1 | busy_rs2;

    assign accept = issue_valid & issue_we & (issue_rd != '0) & ~stall_ID & ~hold;

    // x0 stays zero; an accepted issue overwrites its entry and beats that entry's decrement.
    always_ff @(posedge clk) begin
        cnt[0] <= '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (rst) begin
                cnt[r] <= '0;
            end else if (!hold) begin
                if (accept && (issue_rd == IDX_W'(r))) begin
                    cnt[r] <= issue_lat;
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - LAT_W'(1);
                end
            end
        end
    end

`ifdef SCOREBOARD_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (stall_ID && !hold && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_register_scoreboard.sv
// Self-checking bench for register_scoreboard: directed hazard scenarios plus randomized traffic
// compared each cycle against a per-register "cycles until forwardable" model.
module tb_register_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic        issue_we;
    logic [3:0]  issue_rd;
    logic [1:0]  issue_lat;
    logic        hold;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic        rs1_used;
    logic        rs2_used;
    logic        stall_ID;
    logic        busy_rs1;
    logic        busy_rs2;
    logic [15:0] pending_mask;
`ifdef SCOREBOARD_STATS_EN
    logic [31:0] stall_cycles;
    int unsigned model_stat;
`endif

    int checks = 0;
    int errors = 0;

    // Model: remaining non-hold cycles before each register's value exists for forwarding.
    int  model_wait [16];
    bit  model_live = 1'b0;

    register_scoreboard #(.NUM_REGS(16), .LAT_W(2)) dut (
        .clk(clk),
        .rst(rst),
        .issue_valid(issue_valid),
        .issue_we(issue_we),
        .issue_rd(issue_rd),
        .issue_lat(issue_lat),
        .hold(hold),
        .rs1(rs1),
        .rs2(rs2),
        .rs1_used(rs1_used),
        .rs2_used(rs2_used),
        .stall_ID(stall_ID),
        .busy_rs1(busy_rs1),
        .busy_rs2(busy_rs2),
`ifdef SCOREBOARD_STATS_EN
        .stall_cycles(stall_cycles),
`endif
        .pending_mask(pending_mask)
    );

    always #5 clk = ~clk;

    function automatic bit model_busy(input logic [3:0] r, input logic used);
        return used && (model_wait[r] > 0);
    endfunction

    function automatic bit model_stall();
        return model_busy(rs1, rs1_used) || model_busy(rs2, rs2_used);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            foreach (model_wait[r]) model_wait[r] = 0;
`ifdef SCOREBOARD_STATS_EN
            model_stat = 0;
`endif
            model_live = 1'b1;
        end else if (!hold) begin
            bit stalled;
            bit taken;
            stalled = model_stall();
            taken = issue_valid && issue_we && (issue_rd != 0) && !stalled;
`ifdef SCOREBOARD_STATS_EN
            if (stalled && model_stat != 32'hFFFF_FFFF) model_stat++;
`endif
            foreach (model_wait[r]) begin
                if (taken && r == int'(issue_rd)) model_wait[r] = int'(issue_lat);
                else if (model_wait[r] > 0) model_wait[r]--;
            end
        end
    end

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        logic [15:0] exp_mask;
        if (!model_live) return;
        exp_mask = '0;
        foreach (model_wait[r]) exp_mask[r] = (model_wait[r] > 0);
        checkValue("pending_mask", 32'(pending_mask), 32'(exp_mask));
        checkValue("busy_rs1", 32'(busy_rs1), 32'(model_busy(rs1, rs1_used)));
        checkValue("busy_rs2", 32'(busy_rs2), 32'(model_busy(rs2, rs2_used)));
        checkValue("stall_ID", 32'(stall_ID), 32'(model_stall()));
`ifdef SCOREBOARD_STATS_EN
        checkValue("stall_cycles", stall_cycles, model_stat);
`endif
    endtask

    task automatic applyStimulus(input logic v, input logic we, input logic [3:0] rd,
                                 input logic [1:0] lat, input logic h,
                                 input logic [3:0] r1, input logic u1,
                                 input logic [3:0] r2, input logic u2, input logic rs);
        @(negedge clk);
        issue_valid = v;
        issue_we    = we;
        issue_rd    = rd;
        issue_lat   = lat;
        hold        = h;
        rs1         = r1;
        rs1_used    = u1;
        rs2         = r2;
        rs2_used    = u2;
        rst         = rs;
        #1;
        checkOutput();
    endtask

    task automatic idle(input logic [3:0] r1, input logic u1, input logic h);
        applyStimulus(1'b0, 1'b0, 4'd0, 2'd0, h, r1, u1, 4'd0, 1'b0, 1'b0);
    endtask

    initial begin
        int stall_run;
        logic [3:0] last_rd;
`ifdef SCOREBOARD_STATS_EN
        logic [31:0] stat_before;
`endif
        last_rd = 4'd1;

        applyStimulus(1'b0, 1'b0, 4'd0, 2'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1);

        // Load to x5 issued while a reader of x5 sits in ID: nothing pending yet.
        applyStimulus(1'b1, 1'b1, 4'd5, 2'd3, 1'b0, 4'd5, 1'b1, 4'd0, 1'b0, 1'b0);
        checkValue("reset_stall", 32'(stall_ID), 32'd0);
        checkValue("reset_mask", 32'(pending_mask), 32'd0);
        stall_run = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b1, 4'd9, 2'd0, 1'b0, 4'd5, 1'b1, 4'd0, 1'b0, 1'b0);
            if (i == 0) checkValue("load_mask5", 32'(pending_mask), 32'h0020);
            if (stall_ID) stall_run++;
        end
        checkValue("load_stall_len", 32'(stall_run), 32'd3);
        checkValue("load_mask_clear", 32'(pending_mask), 32'd0);

        // WAW: ALU write to x7 one cycle after a load to x7 erases the pending entry.
        applyStimulus(1'b1, 1'b1, 4'd7, 2'd3, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 4'd7, 2'd0, 1'b0, 4'd2, 1'b1, 4'd0, 1'b0, 1'b0);
        checkValue("waw_pending", 32'(pending_mask), 32'h0080);
        idle(4'd7, 1'b1, 1'b0);
        checkValue("waw_reader_stall", 32'(stall_ID), 32'd0);
        checkValue("waw_mask", 32'(pending_mask), 32'd0);

        // Writes to x0 never create a hazard.
        applyStimulus(1'b1, 1'b1, 4'd0, 2'd3, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        idle(4'd0, 1'b1, 1'b0);
        checkValue("x0_mask", 32'(pending_mask), 32'd0);
        checkValue("x0_stall", 32'(stall_ID), 32'd0);

        // Load to x3 followed by two hold cycles stretches the stall to five cycles.
        applyStimulus(1'b1, 1'b1, 4'd3, 2'd3, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
`ifdef SCOREBOARD_STATS_EN
        stat_before = stall_cycles;
`endif
        stall_run = 0;
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b0, 1'b0, 4'd0, 2'd0, (i < 2), 4'd0, 1'b0, 4'd3, 1'b1, 1'b0);
            if (stall_ID) stall_run++;
        end
        checkValue("hold_stall_len", 32'(stall_run), 32'd5);
        checkValue("hold_busy_rs2", 32'(busy_rs2), 32'd0);
`ifdef SCOREBOARD_STATS_EN
        checkValue("hold_stat_delta", stall_cycles - stat_before, 32'd3);
`endif

        // Reset right after a load discards its pending state.
        applyStimulus(1'b1, 1'b1, 4'd4, 2'd3, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'd0, 2'd0, 1'b0, 4'd4, 1'b1, 4'd0, 1'b0, 1'b1);
        checkValue("prereset_stall", 32'(stall_ID), 32'd1);
        idle(4'd4, 1'b1, 1'b0);
        checkValue("postreset_mask", 32'(pending_mask), 32'd0);
        checkValue("postreset_stall", 32'(stall_ID), 32'd0);

        // Randomized traffic, with readers biased toward recently written registers.
        for (int i = 0; i < 600; i++) begin
            logic [3:0] rd;
            logic [3:0] r1;
            logic [3:0] r2;
            rd = 4'($urandom_range(0, 15));
            r1 = ($urandom_range(0, 1) == 0) ? last_rd : 4'($urandom_range(0, 15));
            r2 = ($urandom_range(0, 2) == 0) ? last_rd : 4'($urandom_range(0, 15));
            applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) != 0), rd,
                          2'($urandom_range(0, 3)), 1'($urandom_range(0, 5) == 0),
                          r1, 1'($urandom_range(0, 3) != 0), r2, 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 79) == 0));
            last_rd = rd;
        end

        idle(4'd0, 1'b0, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
